// File: rtl/sim_status_arb.sv
// Simulation status arbiter: round-robin status-write mux feeding an
// end-of-test FSM (IDLE/RUN/DRAIN/DONE) with a cycle watchdog.
module sim_status_arb #(
  parameter int          N_REQ        = 2,
  parameter int          DRAIN_CYCLES = 16,
  parameter logic [15:0] PASS_CODE    = 16'h900D,
  parameter logic [15:0] FAIL_CODE    = 16'hBAAD
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*32-1:0]      req_addr_i,
  input  logic [N_REQ*16-1:0]      req_data_i,
  input  logic [31:0]              status_addr_i,
  input  logic [31:0]              timeout_cycles_i,
  output logic [15:0]              status_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o,
  output logic                     done_o,
  output logic                     passed_o,
  output logic                     timeout_o,
  output logic [1:0]               state_o
);

  // Handshake: a write transfers on a cycle where req_valid_i[k] and
  // req_ready_o[k] are both 1; ready never depends on the write's own data.

  localparam int              IW         = $clog2(N_REQ);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(N_REQ - 1);
  localparam logic [7:0]      DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_ptr;
  logic [15:0]   r_status;
  logic          r_pass;
  logic          r_timeout;
  logic [7:0]    r_drain;
  logic [31:0]   r_wdog;

  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_grant;
  logic          w_found;
  logic [N_REQ-1:0] w_ready;
  logic [31:0]   w_addr [N_REQ];
  logic [15:0]   w_data [N_REQ];
  logic [31:0]   w_sel_addr;
  logic [15:0]   w_sel_data;
  logic          w_live;
  logic          w_status_wr;
  logic          w_term;
  logic          w_wdog_exp;

  // Search upward from the slot after the last accepted requester.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_ready = '0;
    w_cand  = (r_ptr == LAST_IDX) ? '0 : r_ptr + IW'(1);
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
      w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + IW'(1);
    end
    if (rst_i) begin
      w_found = 1'b0;
      w_grant = '0;
    end
    if (w_found) w_ready[w_grant] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_addr[k] = req_addr_i[32*k +: 32];
      w_data[k] = req_data_i[16*k +: 16];
    end
  end

  assign w_sel_addr  = w_addr[w_grant];
  assign w_sel_data  = w_data[w_grant];
  assign w_live      = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_status_wr = w_found && (w_sel_addr == status_addr_i);
  assign w_term      = w_status_wr && ((w_sel_data == PASS_CODE) || (w_sel_data == FAIL_CODE));
  assign w_wdog_exp  = w_live && (timeout_cycles_i != 32'd0) &&
                       (r_wdog == timeout_cycles_i - 32'd1);

  // A terminal write outranks a same-cycle watchdog expiry.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_term)
          w_state_next = (DRAIN_CYCLES == 1) ? S_DONE : S_DRAIN;
        else if (w_wdog_exp)
          w_state_next = S_DONE;
        else if (w_status_wr)
          w_state_next = S_RUN;
      end
      // Leaving on count 1 makes the counter hit 0 as DONE is entered.
      S_DRAIN: if (r_drain <= 8'd1) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= LAST_IDX;
      r_status  <= 16'd0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_drain   <= 8'd0;
      r_wdog    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_found) r_ptr <= w_grant;
      if (w_live && w_status_wr) r_status <= w_sel_data;
      if (w_live && w_term) begin
        r_pass  <= (w_sel_data == PASS_CODE);
        r_drain <= DRAIN_LOAD;
      end else if (r_state == S_DRAIN && r_drain != 8'd0) begin
        r_drain <= r_drain - 8'd1;
      end
      if (w_live && !w_term && w_wdog_exp) r_timeout <= 1'b1;
      if (w_live && r_wdog != 32'hFFFF_FFFF) r_wdog <= r_wdog + 32'd1;
    end
  end

  assign req_ready_o = w_ready;
  assign grant_idx_o = w_grant;
  assign status_o    = r_status;
  assign done_o      = (r_state == S_DONE);
  assign passed_o    = (r_state == S_DONE) && r_pass;
  assign timeout_o   = r_timeout;
  assign state_o     = r_state;

endmodule

// File: tb/tb_sim_status_arb.sv
// Directed bench for sim_status_arb: arbitration, status FSM, drain timing,
// watchdog and reset abort, checked with immediate assertions.
module tb_sim_status_arb;

  localparam logic [31:0] SADDR = 32'h1000_0000;
  localparam logic [1:0]  ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3;

  logic        clk;
  logic        rst;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [63:0] addr;
  logic [31:0] data;
  logic [31:0] saddr;
  logic [31:0] tmo;
  logic [15:0] status;
  logic        gidx;
  logic        done;
  logic        passed;
  logic        tout;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  sim_status_arb #(.N_REQ(2), .DRAIN_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_addr_i(addr), .req_data_i(data),
    .status_addr_i(saddr), .timeout_cycles_i(tmo),
    .status_o(status), .grant_idx_o(gidx),
    .done_o(done), .passed_o(passed), .timeout_o(tout),
    .state_o(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL bench_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int k, input logic [31:0] a, input logic [15:0] d);
    valid[k]         = 1'b1;
    addr[32*k +: 32] = a;
    data[16*k +: 16] = d;
  endtask

  task automatic do_reset(input logic [31:0] t);
    rst   = 1'b1;
    valid = 2'b00;
    tmo   = t;
    repeat (2) step();
    rst   = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 2'b11;
    addr  = '0;
    data  = '0;
    saddr = SADDR;
    tmo   = 32'd0;

    // reset values, including ready held low despite valid requests
    repeat (3) step();
    settle();
    check("rst_ready", ready, 2'b00);
    check("rst_status", status, 16'h0000);
    check("rst_done", done, 1'b0);
    check("rst_passed", passed, 1'b0);
    check("rst_timeout", tout, 1'b0);
    check("rst_grant", gidx, 1'b0);
    check("rst_state", state, ST_IDLE);
    step();
    rst = 1'b0;

    // round robin with both requesters valid (non-status address, dropped)
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("rr_grant%0d", i), gidx, (i % 2));
      check($sformatf("rr_ready%0d", i), ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    valid = 2'b00;
    check("rr_drop_status", status, 16'h0000);
    check("rr_drop_state", state, ST_IDLE);

    // progress code then PASS; DONE exactly 16 cycles after the PASS accept
    drive(0, SADDR, 16'h4354);
    settle();
    check("pass_ready0", ready, 2'b01);
    step();
    drive(0, SADDR, 16'h900D);
    check("pass_status_prog", status, 16'h4354);
    check("pass_state_run", state, ST_RUN);
    settle();
    check("pass_ready1", ready, 2'b01);
    step();
    valid = 2'b00;
    check("pass_status", status, 16'h900D);
    check("pass_state_drain", state, ST_DRAIN);
    check("pass_done_early", done, 1'b0);
    check("pass_passed_early", passed, 1'b0);
    drive(1, SADDR, 16'hBAAD);
    settle();
    check("drain_ready", ready, 2'b10);
    step();
    valid = 2'b00;
    check("drain_status_frozen", status, 16'h900D);
    repeat (13) step();
    check("pass_done_c15", done, 1'b0);
    step();
    check("pass_done_c16", done, 1'b1);
    check("pass_passed", passed, 1'b1);
    check("pass_timeout", tout, 1'b0);
    drive(0, SADDR, 16'h4354);
    settle();
    check("done_ready", ready, 2'b01);
    step();
    valid = 2'b00;
    check("done_status_frozen", status, 16'h900D);
    check("done_passed_frozen", passed, 1'b1);
    check("done_state", state, ST_DONE);

    // reset in the middle of DRAIN aborts with no done pulse
    do_reset(32'd0);
    drive(0, SADDR, 16'h900D);
    step();
    valid = 2'b00;
    check("abort_state_drain", state, ST_DRAIN);
    repeat (4) step();
    rst = 1'b1;
    step();
    check("abort_state_idle", state, ST_IDLE);
    check("abort_done", done, 1'b0);
    check("abort_status", status, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("abort_no_done%0d", i), done, 1'b0);
    end
    drive(0, SADDR, 16'h900D);
    settle();
    check("abort_retry_ready", ready, 2'b01);
    step();
    valid = 2'b00;
    repeat (14) step();
    check("abort_retry_c15", done, 1'b0);
    step();
    check("abort_retry_done", done, 1'b1);
    check("abort_retry_passed", passed, 1'b1);

    // FAIL code at the wrong address is dropped, then at the right one
    do_reset(32'd0);
    drive(0, SADDR + 32'd4, 16'hBAAD);
    step();
    valid = 2'b00;
    check("fail_wrong_addr_status", status, 16'h0000);
    check("fail_wrong_addr_state", state, ST_IDLE);
    drive(0, SADDR, 16'hBAAD);
    step();
    valid = 2'b00;
    check("fail_status", status, 16'hBAAD);
    check("fail_state_drain", state, ST_DRAIN);
    repeat (14) step();
    check("fail_done_c15", done, 1'b0);
    step();
    check("fail_done", done, 1'b1);
    check("fail_passed", passed, 1'b0);
    check("fail_timeout", tout, 1'b0);

    // watchdog of 100 cycles with no status writes
    do_reset(32'd100);
    repeat (99) step();
    check("wdog_done_c99", done, 1'b0);
    check("wdog_state_c99", state, ST_IDLE);
    step();
    check("wdog_done_c100", done, 1'b1);
    check("wdog_timeout", tout, 1'b1);
    check("wdog_passed", passed, 1'b0);
    repeat (5) step();
    check("wdog_sticky_state", state, ST_DONE);
    check("wdog_sticky_timeout", tout, 1'b1);

    // PASS accepted in the same cycle the 50-cycle watchdog expires
    do_reset(32'd50);
    repeat (49) step();
    drive(0, SADDR, 16'h900D);
    settle();
    check("race_ready", ready, 2'b01);
    step();
    valid = 2'b00;
    check("race_state_drain", state, ST_DRAIN);
    check("race_timeout", tout, 1'b0);
    check("race_status", status, 16'h900D);
    repeat (14) step();
    check("race_done_c15", done, 1'b0);
    step();
    check("race_done", done, 1'b1);
    check("race_passed", passed, 1'b1);
    check("race_timeout_final", tout, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
